// File: rtl/cp0_pkg.sv
// -----------------------------------------------------------------------------
// cp0_pkg
// Shared definitions for the coprocessor-0 control block: CP0 register
// numbers, Status/Cause bit positions, exception codes, the Status reset
// value and helpers that assemble the architected Status/Cause words.
// -----------------------------------------------------------------------------
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // Status bit positions
    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int ST_BEV   = 22;

    // Cause bit positions
    localparam int CA_EXC_LO = 2;
    localparam int CA_IP_LO  = 8;
    localparam int CA_TI     = 30;
    localparam int CA_BD     = 31;

    // Cause.ExcCode values
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // BEV is hard-wired to 1; everything else clears on reset
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    // Assemble the software-visible Status word from its live fields.
    function automatic logic [31:0] pack_status(input logic [7:0] im,
                                                input logic       exl,
                                                input logic       ie);
        logic [31:0] w;
        w                         = STATUS_RESET;
        w[ST_IM_LO +: 8]          = im;
        w[ST_EXL]                 = exl;
        w[ST_IE]                  = ie;
        return w;
    endfunction

    // Assemble the software-visible Cause word from its live fields.
    function automatic logic [31:0] pack_cause(input logic       bd,
                                               input logic       ti,
                                               input logic [7:0] ip,
                                               input logic [4:0] exc_code);
        logic [31:0] w;
        w                         = 32'h0;
        w[CA_BD]                  = bd;
        w[CA_TI]                  = ti;
        w[CA_IP_LO +: 8]          = ip;
        w[CA_EXC_LO +: 5]         = exc_code;
        return w;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
// Count/Compare timer. A divider runs 0..COUNT_DIV-1 and Count increments
// when it wraps. TI is a sticky flag set the cycle after the registered
// Count equals the registered Compare, and cleared by a write to Compare.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   count_we       MTC0 write to Count (loads wdata, restarts the divider)
//   compare_we     MTC0 write to Compare (loads wdata, clears TI)
//   wdata          MTC0 data
//   count          current Count
//   compare        current Compare
//   ti             timer interrupt flag
// -----------------------------------------------------------------------------
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int             DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             ti_q, ti_d;
    logic             div_wrap;

    always_comb begin
        div_wrap  = (div_q == DIV_LAST);
        div_d     = div_wrap ? '0 : div_q + 1'b1;
        count_d   = div_wrap ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        // A software load of Count wins over the increment and restarts
        // the prescaler so the next tick is a full COUNT_DIV away.
        if (count_we) begin
            count_d = wdata;
            div_d   = '0;
        end

        if (count_q == compare_q) begin
            ti_d = 1'b1;
        end

        // Writing Compare acknowledges the interrupt, even on a match cycle.
        if (compare_we) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            count_q   <= 32'h0;
            compare_q <= 32'h0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_ctrl
// Coprocessor-0 control block: Status, Cause, EPC, BadVAddr plus the
// Count/Compare timer. Handles exception entry, ERET, MTC0/MFC0 access and
// hardware interrupt synchronisation, and raises int_req for an enabled,
// pending interrupt.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   wen/waddr/wdata       MTC0 write
//   raddr/rdata           MFC0 read (combinational, pre-write value)
//   exception, exc_*      exception commit and its attributes
//   eret                  ERET commit
//   hw_int                level-sensitive hardware interrupt lines
//   epc, status_exl       current EPC and Status.EXL
//   int_req               pending enabled interrupt
// -----------------------------------------------------------------------------
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int COUNT_DIV   = 2,
    parameter int HW_INT_N    = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wen,
    input  logic [4:0]          waddr,
    input  logic [31:0]         wdata,
    input  logic [4:0]          raddr,
    output logic [31:0]         rdata,
    input  logic                exception,
    input  logic [4:0]          exc_code,
    input  logic [31:0]         exc_pc,
    input  logic                exc_bd,
    input  logic                exc_badvaddr_vld,
    input  logic [31:0]         exc_badvaddr,
    input  logic                eret,
    input  logic [HW_INT_N-1:0] hw_int,
    output logic [31:0]         epc,
    output logic                status_exl,
    output logic                int_req
);

    // Status fields
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    // Cause fields
    logic        bd_q, bd_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    // Other registers
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic [5:0]  hw_sync;
    logic [7:0]  ip;
    logic [31:0] count, compare;
    logic        ti;
    logic        count_we, compare_we;
    logic        wr_status, wr_cause, wr_epc;

    // ---------------------------------------------------------------------
    // Hardware interrupt synchronisers: SYNC_STAGES flops per line, followed
    // by the Cause.IP register itself. Lines beyond HW_INT_N read 0.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_line
            if (gi < HW_INT_N) begin : g_used
                if (SYNC_STAGES == 0) begin : g_direct
                    assign hw_sync[gi] = hw_int[gi];
                end else begin : g_sync
                    logic [SYNC_STAGES-1:0] sync_q, sync_d;

                    always_comb begin
                        sync_d[0] = hw_int[gi];
                        for (int k = 1; k < SYNC_STAGES; k++) begin
                            sync_d[k] = sync_q[k-1];
                        end
                    end

                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) begin
                            sync_q <= '0;
                        end else begin
                            sync_q <= sync_d;
                        end
                    end

                    assign hw_sync[gi] = sync_q[SYNC_STAGES-1];
                end
            end else begin : g_unused
                assign hw_sync[gi] = 1'b0;
            end
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Timer
    // ---------------------------------------------------------------------
    assign count_we   = wen && (waddr == REG_COUNT);
    assign compare_we = wen && (waddr == REG_COMPARE);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (count_we),
        .compare_we (compare_we),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // ---------------------------------------------------------------------
    // Architected state update. Exception beats ERET beats MTC0 for any
    // register they both touch; MTC0 to unrelated registers still lands.
    // ---------------------------------------------------------------------
    assign wr_status = wen && (waddr == REG_STATUS) && !exception && !eret;
    assign wr_cause  = wen && (waddr == REG_CAUSE)  && !exception;
    assign wr_epc    = wen && (waddr == REG_EPC)    && !exception;

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        ip_sw_d    = ip_sw_q;
        ip_hw_d    = hw_sync;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        if (exception) begin
            exc_code_d = exc_code;
            exl_d      = 1'b1;
            // Nested exceptions keep the original return point.
            if (!exl_q) begin
                epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
                bd_d  = exc_bd;
            end
            if (exc_badvaddr_vld) begin
                badvaddr_d = exc_badvaddr;
            end
        end else if (eret) begin
            exl_d = 1'b0;
        end

        if (wr_status) begin
            im_d  = wdata[ST_IM_LO +: 8];
            exl_d = wdata[ST_EXL];
            ie_d  = wdata[ST_IE];
        end
        if (wr_cause) begin
            ip_sw_d = wdata[CA_IP_LO +: 2];
        end
        if (wr_epc) begin
            epc_d = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_q       <= 8'h0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= 5'h0;
            ip_sw_q    <= 2'b0;
            ip_hw_q    <= 6'h0;
            epc_q      <= 32'h0;
            badvaddr_q <= 32'h0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // IP[7] shares the timer with hw_int[5]; ip_hw_q[5] is 0 when that
    // line does not exist, leaving TI alone.
    assign ip = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};

    // ---------------------------------------------------------------------
    // MFC0 read and status outputs
    // ---------------------------------------------------------------------
    always_comb begin
        rdata = 32'h0;
        case (raddr)
            REG_BADVADDR: rdata = badvaddr_q;
            REG_COUNT:    rdata = count;
            REG_COMPARE:  rdata = compare;
            REG_STATUS:   rdata = pack_status(im_q, exl_q, ie_q);
            REG_CAUSE:    rdata = pack_cause(bd_q, ti, ip, exc_code_q);
            REG_EPC:      rdata = epc_q;
            default:      rdata = 32'h0;
        endcase
    end

    assign epc        = epc_q;
    assign status_exl = exl_q;
    assign int_req    = ie_q && !exl_q && (|(ip & im_q));

endmodule
